// File: rtl/lab3_serial_pkg.sv
// Shared types and constants for the lab3 serial transmitter.
// Holds the FSM state encoding and frame-level constants.
package lab3_serial_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

endpackage

// File: rtl/lab3_bit_timer.sv
// Bit-period timer: counts BIT_CYCLES clocks per serial bit.
// tick is high on the last cycle of each bit period.
module lab3_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lab3_serial_tx.sv
// Serial byte transmitter: start bit, 8 data bits LSB first,
// optional even parity, one stop bit; tx is driven from a flop.
module lab3_serial_tx
  import lab3_serial_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  state_e         state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           clear;
  logic           tick;

  lab3_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  // tx_d is the level of the bit about to start, so tx_q changes
  // exactly on bit boundaries.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        clear  = 1'b1;
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_START;
          shift_d = data_in;
          par_d   = ^data_in;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = IDLE_LEVEL;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = IDLE_LEVEL;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_d = S_IDLE;
          tx_d    = IDLE_LEVEL;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_lab3_serial_tx.sv
// Bench for lab3_serial_tx: three configurations checked against
// a per-cycle frame model built from the bit sequence of each byte.
module tb_lab3_serial_tx;

  logic       clk;
  logic       rst;
  logic [2:0] st;
  logic [7:0] din [3];
  logic [2:0] txv;
  logic [2:0] bsy;
  logic [2:0] dn;

  int bcs [3] = '{4, 4, 1};
  int pes [3] = '{1, 0, 1};

  int nchk;
  int nerr;

  lab3_serial_tx #(.BIT_CYCLES(4), .PARITY_EN(1'b1)) dut0 (
    .clock(clk), .reset(rst), .start(st[0]), .data_in(din[0]),
    .tx(txv[0]), .busy(bsy[0]), .done(dn[0])
  );

  lab3_serial_tx #(.BIT_CYCLES(4), .PARITY_EN(1'b0)) dut1 (
    .clock(clk), .reset(rst), .start(st[1]), .data_in(din[1]),
    .tx(txv[1]), .busy(bsy[1]), .done(dn[1])
  );

  lab3_serial_tx #(.BIT_CYCLES(1), .PARITY_EN(1'b1)) dut2 (
    .clock(clk), .reset(rst), .start(st[2]), .data_in(din[2]),
    .tx(txv[2]), .busy(bsy[2]), .done(dn[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       par;
    int         len;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int k, input logic a,
                     input logic e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s dut%0d t=%0t: got %b want %b", nm, k, $time, a, e);
    end
  endtask

  // Level expected on tx at cycle c (0-based) of a frame.
  function automatic logic exp_bit(input int bc, input int pe,
                                   input logic [7:0] d, input logic par,
                                   input int c);
    int slot;
    slot = c / bc;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (pe != 0 && slot == 9) return par;
    return 1'b1;
  endfunction

  // Call at a negedge; returns at the negedge of the done cycle.
  task automatic frame(input int k, input logic [7:0] d, input logic par,
                       input int n, input bit hold, input int inj);
    st[k]  = 1'b1;
    din[k] = d;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      chk("tx", k, txv[k], exp_bit(bcs[k], pes[k], d, par, c - 1));
      chk("busy", k, bsy[k], 1'b1);
      chk("done", k, dn[k], 1'b0);
      if (!hold) st[k] = (c == inj);
      din[k] = (c == inj) ? 8'h3C : 8'($urandom);
    end
    @(negedge clk);
    chk("tx_end", k, txv[k], 1'b1);
    chk("busy_end", k, bsy[k], 1'b0);
    chk("done_end", k, dn[k], 1'b1);
  endtask

  task automatic idle(input int k, input int n);
    st[k] = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_tx", k, txv[k], 1'b1);
      chk("idle_busy", k, bsy[k], 1'b0);
      chk("idle_done", k, dn[k], 1'b0);
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    st   = 3'b111;
    for (int i = 0; i < 3; i++) din[i] = 8'hA5;
    rst  = 1'b1;

    vecs[0] = '{k: 0, d: 8'hA5, par: 1'b0, len: 44};
    vecs[1] = '{k: 1, d: 8'h07, par: 1'b1, len: 40};
    vecs[2] = '{k: 2, d: 8'hA5, par: 1'b0, len: 11};
    vecs[3] = '{k: 2, d: 8'h80, par: 1'b1, len: 11};
    vecs[4] = '{k: 0, d: 8'h00, par: 1'b0, len: 44};
    vecs[5] = '{k: 1, d: 8'hFF, par: 1'b0, len: 40};

    // Reset held 3 edges with start high: nothing may be accepted.
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 3; k++) begin
        chk("rst_tx", k, txv[k], 1'b1);
        chk("rst_busy", k, bsy[k], 1'b0);
        chk("rst_done", k, dn[k], 1'b0);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    st  = 3'b000;
    for (int k = 0; k < 3; k++) idle(k, 2);

    for (int i = 0; i < 6; i++) begin
      frame(vecs[i].k, vecs[i].d, vecs[i].par, vecs[i].len, 1'b0, 0);
      idle(vecs[i].k, 2);
    end

    // Start pulse with another byte mid-frame must be ignored.
    frame(0, 8'hA5, 1'b0, 44, 1'b0, 10);
    idle(0, 6);

    // Start held high: second frame begins right after the done cycle.
    frame(0, 8'h01, 1'b1, 44, 1'b1, 0);
    frame(0, 8'hFF, 1'b0, 44, 1'b1, 0);
    idle(0, 3);

    // Mid-frame reset at cycle 17.
    st[0]  = 1'b1;
    din[0] = 8'hA5;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("pre_rst_tx", 0, txv[0], exp_bit(4, 1, 8'hA5, 1'b0, c - 1));
      st[0] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_tx", 0, txv[0], 1'b1);
    chk("arst_busy", 0, bsy[0], 1'b0);
    chk("arst_done", 0, dn[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(0, 48);
    frame(0, 8'hA5, 1'b0, 44, 1'b0, 0);
    idle(0, 2);

    // Random bytes against the model, all configurations.
    for (int i = 0; i < 12; i++) begin
      int k;
      logic [7:0] d;
      k = i % 3;
      d = 8'($urandom);
      frame(k, d, ^d, (10 + pes[k]) * bcs[k], $urandom_range(0, 1) == 1, 0);
      idle(k, 2);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/lab3_serial_tx.md
LAB3_SERIAL_TX -- requirements
Module: lab3_serial_tx

Interface
REQ-001 Parameter BIT_CYCLES, default 4, SHALL set the clock cycles each serial bit is held (legal range 1..255).
REQ-002 Parameter PARITY_EN, default 1, SHALL insert an even-parity bit when 1 and omit it when 0.
REQ-003 clock  input  1  SHALL be the single clock; all state updates occur on posedge clock.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL be the request to send data_in; it is sampled only in IDLE.
REQ-006 data_in  input  8  SHALL be the byte to transmit; it is latched on the accepting edge.
REQ-007 tx  output  1  SHALL be the registered serial line; it is high when idle.
REQ-008 busy  output  1  SHALL be high from the accepting edge through the last stop-bit cycle.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking frame completion.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-011 IDLE with start=1 at an edge SHALL latch data_in, enter START, drive tx=0 and busy=1 from that edge.
REQ-012 Each state SHALL hold tx for exactly BIT_CYCLES cycles, timed by a bit counter that wraps to 0 at BIT_CYCLES-1.
REQ-013 DATA SHALL shift the 8 bits LSB first, using a bit index 0..7, and leave after index 7 completes.
REQ-014 After DATA, the FSM SHALL go to PARITY if PARITY_EN=1 and to STOP otherwise; the PARITY bit SHALL be the XOR of the 8 latched bits.
REQ-015 STOP SHALL drive tx=1 for BIT_CYCLES cycles, then return to IDLE.
REQ-016 The frame length SHALL be (10+PARITY_EN)*BIT_CYCLES cycles, measured from the accepting edge to busy falling.
REQ-017 On the IDLE-entry edge, busy SHALL fall and done SHALL rise for one cycle.
REQ-018 start while busy=1 SHALL be ignored, and data_in changes mid-frame SHALL have no effect.
REQ-019 start=1 in the cycle where done=1 SHALL be accepted, giving back-to-back frames with no idle gap beyond the stop bit.
REQ-020 With BIT_CYCLES=1, every bit SHALL last exactly one cycle, with no skipped or duplicated bits.
REQ-021 tx SHALL be glitch-free, being driven directly from a flop.

Reset
REQ-022 Asserting reset SHALL immediately force tx=1, busy=0, done=0, state=IDLE, and the bit counter, bit index and shift register to 0.
REQ-023 Reset mid-frame SHALL abort the frame with no done pulse; the first start after reset deasserts SHALL begin a fresh frame.
REQ-024 No start SHALL be accepted on the edge at which reset is still high.

Structure
REQ-025 Package lab3_serial_pkg SHALL hold the state enum, DATA_BITS=8 and the IDLE_LEVEL=1 constant.
REQ-026 Sub-module lab3_bit_timer SHALL hold the BIT_CYCLES counter, with inputs clock, reset and clear, and output tick high on the last cycle of a bit.
REQ-027 All FSM, shift and output logic SHALL reside in lab3_serial_tx.

Verification
REQ-028 Reset test: hold reset for 3 cycles, then release -> tx=1, busy=0, done=0 throughout; no activity without start.
REQ-029 Basic frame: BIT_CYCLES=4, PARITY_EN=1, data_in=8'hA5, one-cycle start -> tx is 0, then 1,0,1,0,0,1,0,1, then parity 0, then 1, each for 4 cycles; busy lasts 44 cycles; done pulses once at cycle 44.
REQ-030 No-parity frame: PARITY_EN=0, data_in=8'h07 -> tx is 0, then 1,1,1,0,0,0,0,0, then 1; busy lasts 40 cycles; the parity bit is absent.
REQ-031 Busy protection: pulse start with 8'h3C at cycle 10 of an 8'hA5 frame -> the frame is unchanged and no second frame follows.
REQ-032 Back-to-back: start held high, data 8'h01 then 8'hFF -> the second start bit begins the cycle after the first stop bit; 8'hFF parity is 0.
REQ-033 Mid-frame reset: assert reset at cycle 17 of an 8'hA5 frame -> tx=1 and busy=0 asynchronously with no done; a new start then yields a full correct frame.
